// File: rtl/ns_chnl_arbiter.sv
// ns_chnl_arbiter: round-robin arbiter that buffers one message from i0/i1 and replays it on o0 (4-phase).
// Optional redundancy check of buffered messages is enabled by defining NS_ARB_REDUN_CHECK_EN.

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 8
`endif

`ifdef NS_ARB_REDUN_CHECK_EN
// Redundancy is the XOR-fold of {src, dst, dat} onto RSZ bits.
module calc_redun #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE
) (
    input  logic [ASZ-1:0] i_src,
    input  logic [ASZ-1:0] i_dst,
    input  logic [DSZ-1:0] i_dat,
    output logic [RSZ-1:0] o_red
);
    localparam int MW = 2*ASZ + DSZ;
    logic [MW-1:0] w_msg;

    assign w_msg = {i_src, i_dst, i_dat};

    always_comb begin
        o_red = '0;
        for (int i = 0; i < MW; i++) begin
            o_red[i % RSZ] = o_red[i % RSZ] ^ w_msg[i];
        end
    end
endmodule
`endif

// state   | meaning
// S_IDLE  | waiting for a request; arbitrates and latches the winner
// S_IACK  | ack held to granted input until its req drops
// S_OREQ  | o0_req high, waiting for o0_ack
// S_ODONE | waiting for o0_ack to fall
module ns_chnl_arbiter #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE
) (
    input  logic           src_clk,
    input  logic           reset,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    input  logic           i0_req,
    output logic           i0_ack,
    input  logic [ASZ-1:0] i1_src,
    input  logic [ASZ-1:0] i1_dst,
    input  logic [DSZ-1:0] i1_dat,
    input  logic [RSZ-1:0] i1_red,
    input  logic           i1_req,
    output logic           i1_ack,
    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic [RSZ-1:0] o0_red,
    output logic           o0_req,
    input  logic           o0_ack,
    output logic [7:0]     fwd_cnt,
    output logic [7:0]     err_cnt,
    output logic           last_gnt
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_IACK  = 2'd1;
    localparam logic [1:0] S_OREQ  = 2'd2;
    localparam logic [1:0] S_ODONE = 2'd3;

    logic [1:0]     r_state;
    logic           r_i0_ack;
    logic           r_i1_ack;
    logic           r_o0_req;
    logic           r_last_gnt;
    logic [ASZ-1:0] r_o0_src;
    logic [ASZ-1:0] r_o0_dst;
    logic [DSZ-1:0] r_o0_dat;
    logic [RSZ-1:0] r_o0_red;
    logic [7:0]     r_fwd_cnt;

    logic           w_gnt_any;
    logic           w_gnt_idx;
    logic           w_gnt_req;
    logic           w_red_ok;

    assign w_gnt_any = i0_req | i1_req;
    // On contention the input that did not win last time goes first.
    assign w_gnt_idx = (i0_req & i1_req) ? ~r_last_gnt : i1_req;
    assign w_gnt_req = r_last_gnt ? i1_req : i0_req;

`ifdef NS_ARB_REDUN_CHECK_EN
    logic [RSZ-1:0] w_red_calc;
    logic [7:0]     r_err_cnt;

    calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_calc_redun (
        .i_src (r_o0_src),
        .i_dst (r_o0_dst),
        .i_dat (r_o0_dat),
        .o_red (w_red_calc)
    );

    assign w_red_ok = (w_red_calc == r_o0_red);
    assign err_cnt  = r_err_cnt;
`else
    assign w_red_ok = 1'b1;
    assign err_cnt  = 8'd0;
`endif

    always_ff @(posedge src_clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_i0_ack   <= 1'b0;
            r_i1_ack   <= 1'b0;
            r_o0_req   <= 1'b0;
            r_last_gnt <= 1'b1;
            r_o0_src   <= '0;
            r_o0_dst   <= '0;
            r_o0_dat   <= '0;
            r_o0_red   <= '0;
            r_fwd_cnt  <= 8'd0;
`ifdef NS_ARB_REDUN_CHECK_EN
            r_err_cnt  <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        r_last_gnt <= w_gnt_idx;
                        r_state    <= S_IACK;
                        if (w_gnt_idx) begin
                            r_o0_src <= i1_src;
                            r_o0_dst <= i1_dst;
                            r_o0_dat <= i1_dat;
                            r_o0_red <= i1_red;
                            r_i1_ack <= 1'b1;
                        end else begin
                            r_o0_src <= i0_src;
                            r_o0_dst <= i0_dst;
                            r_o0_dat <= i0_dat;
                            r_o0_red <= i0_red;
                            r_i0_ack <= 1'b1;
                        end
                    end
                end
                S_IACK: begin
                    if (!w_gnt_req) begin
                        r_i0_ack <= 1'b0;
                        r_i1_ack <= 1'b0;
                        if (w_red_ok) begin
                            r_o0_req <= 1'b1;
                            r_state  <= S_OREQ;
                        end else begin
`ifdef NS_ARB_REDUN_CHECK_EN
                            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
`endif
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_OREQ: begin
                    if (o0_ack) begin
                        r_o0_req  <= 1'b0;
                        r_fwd_cnt <= r_fwd_cnt + 8'd1;
                        r_state   <= S_ODONE;
                    end
                end
                S_ODONE: begin
                    if (!o0_ack) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign i0_ack   = r_i0_ack;
    assign i1_ack   = r_i1_ack;
    assign o0_req   = r_o0_req;
    assign o0_src   = r_o0_src;
    assign o0_dst   = r_o0_dst;
    assign o0_dat   = r_o0_dat;
    assign o0_red   = r_o0_red;
    assign fwd_cnt  = r_fwd_cnt;
    assign last_gnt = r_last_gnt;
endmodule

// File: tb/tb_ns_chnl_arbiter.sv
// tb_ns_chnl_arbiter: scoreboard bench for ns_chnl_arbiter; honours NS_ARB_REDUN_CHECK_EN when defined.
module tb_ns_chnl_arbiter;
`ifdef NS_ADDRESS_SIZE
    localparam int ASZ = `NS_ADDRESS_SIZE;
`else
    localparam int ASZ = 8;
`endif
`ifdef NS_DATA_SIZE
    localparam int DSZ = `NS_DATA_SIZE;
`else
    localparam int DSZ = 16;
`endif
`ifdef NS_REDUN_SIZE
    localparam int RSZ = `NS_REDUN_SIZE;
`else
    localparam int RSZ = 8;
`endif

    typedef struct packed {
        logic [ASZ-1:0] src;
        logic [ASZ-1:0] dst;
        logic [DSZ-1:0] dat;
        logic [RSZ-1:0] red;
    } msg_t;

    logic           src_clk = 1'b0;
    logic           reset = 1'b0;
    logic [ASZ-1:0] i0_src = '0, i0_dst = '0, i1_src = '0, i1_dst = '0;
    logic [DSZ-1:0] i0_dat = '0, i1_dat = '0;
    logic [RSZ-1:0] i0_red = '0, i1_red = '0;
    logic           i0_req = 1'b0, i1_req = 1'b0, o0_ack = 1'b0;
    logic           i0_ack, i1_ack, o0_req, last_gnt;
    logic [ASZ-1:0] o0_src, o0_dst;
    logic [DSZ-1:0] o0_dat;
    logic [RSZ-1:0] o0_red;
    logic [7:0]     fwd_cnt, err_cnt;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   oreq_rises = 0;
    int   oreq_cyc = 0;
    int   pulse_w = 0;
    int   last_w = 0;
    int   ack_cyc[2];
    int   sink_mode = 0;
    bit   i1_seen = 1'b0;
    msg_t exp_q[$];

    ns_chnl_arbiter #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
        .src_clk (src_clk), .reset (reset),
        .i0_src (i0_src), .i0_dst (i0_dst), .i0_dat (i0_dat), .i0_red (i0_red),
        .i0_req (i0_req), .i0_ack (i0_ack),
        .i1_src (i1_src), .i1_dst (i1_dst), .i1_dat (i1_dat), .i1_red (i1_red),
        .i1_req (i1_req), .i1_ack (i1_ack),
        .o0_src (o0_src), .o0_dst (o0_dst), .o0_dat (o0_dat), .o0_red (o0_red),
        .o0_req (o0_req), .o0_ack (o0_ack),
        .fwd_cnt (fwd_cnt), .err_cnt (err_cnt), .last_gnt (last_gnt)
    );

    initial forever #5 src_clk = ~src_clk;
    initial forever begin
        @(posedge src_clk);
        cyc++;
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [RSZ-1:0] red_of(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                                               input logic [DSZ-1:0] t);
        logic [2*ASZ+DSZ-1:0] m;
        logic [RSZ-1:0]       r;
        m = {s, d, t};
        r = '0;
        for (int i = 0; i < 2*ASZ+DSZ; i++) r[i % RSZ] = r[i % RSZ] ^ m[i];
        return r;
    endfunction

    function automatic msg_t mk(input int s, input int d, input int t, input bit bad);
        msg_t m;
        m.src = s[ASZ-1:0];
        m.dst = d[ASZ-1:0];
        m.dat = t[DSZ-1:0];
        m.red = red_of(m.src, m.dst, m.dat) ^ {{(RSZ-1){1'b0}}, bad};
        return m;
    endfunction

    // Output sink: mode 0 acks one sample after req, mode 1 stalls, mode 2 holds ack high.
    initial begin
        logic seen;
        seen = 1'b0;
        forever begin
            @(posedge src_clk);
            #1;
            case (sink_mode)
                1:       begin o0_ack = 1'b0; seen = 1'b0; end
                2:       begin o0_ack = 1'b1; seen = 1'b1; end
                default: begin o0_ack = seen; seen = o0_req; end
            endcase
        end
    end

    // Output monitor: pops the scoreboard on every o0_req rise.
    initial begin
        logic prev_oreq;
        msg_t cur, prev_msg, e;
        prev_oreq = 1'b0;
        prev_msg  = '0;
        forever begin
            @(negedge src_clk);
            cur = {o0_src, o0_dst, o0_dat, o0_red};
            if (i1_ack) i1_seen = 1'b1;
            if (i0_ack && i1_ack) check_val("dual_ack", {i0_ack, i1_ack}, 2'b01);
            if (o0_req && !prev_oreq) begin
                oreq_rises++;
                oreq_cyc = cyc;
                pulse_w  = 1;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_o0_msg", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_val("o0_msg", cur, e);
                end
            end else if (o0_req) begin
                pulse_w++;
                if (cur != prev_msg) check_val("o0_stable", cur, prev_msg);
            end else if (prev_oreq) begin
                last_w = pulse_w;
            end
            prev_oreq = o0_req;
            prev_msg  = cur;
        end
    end

    task automatic send(input int ch, input msg_t m);
        int n;
        @(posedge src_clk);
        #1;
        if (ch == 0) begin
            i0_src = m.src; i0_dst = m.dst; i0_dat = m.dat; i0_red = m.red; i0_req = 1'b1;
        end else begin
            i1_src = m.src; i1_dst = m.dst; i1_dat = m.dat; i1_red = m.red; i1_req = 1'b1;
        end
        n = 0;
        do begin
            @(negedge src_clk);
            n++;
        end while (((ch == 0) ? i0_ack : i1_ack) == 1'b0 && n < 50);
        check_val((ch == 0) ? "i0_ack_rise" : "i1_ack_rise", (ch == 0) ? i0_ack : i1_ack, 1);
        ack_cyc[ch] = cyc;
        @(posedge src_clk);
        #1;
        if (ch == 0) i0_req = 1'b0;
        else         i1_req = 1'b0;
        n = 0;
        do begin
            @(negedge src_clk);
            n++;
        end while (((ch == 0) ? i0_ack : i1_ack) == 1'b1 && n < 50);
        check_val((ch == 0) ? "i0_ack_fall" : "i1_ack_fall", (ch == 0) ? i0_ack : i1_ack, 0);
    endtask

    task automatic wait_fwd(input int exp);
        int n;
        n = 0;
        while (fwd_cnt != exp[7:0] && n < 200) begin
            @(negedge src_clk);
            n++;
        end
        check_val("fwd_cnt", fwd_cnt, exp[7:0]);
        repeat (3) @(negedge src_clk);
    endtask

    task automatic apply_reset();
        check_val("sb_empty", exp_q.size(), 0);
        exp_q.delete();
        sink_mode = 0;
        @(negedge src_clk);
        reset = 1'b0;
        repeat (3) @(negedge src_clk);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        msg_t m_a, m_b, m_c, m_d, m_e, m_f;
        int   n, r0, w_c;

        // Power-on reset values
        repeat (3) @(negedge src_clk);
        check_val("rst_o0_req", o0_req, 0);
        check_val("rst_acks", {i0_ack, i1_ack}, 0);
        check_val("rst_cnts", {fwd_cnt, err_cnt}, 0);
        check_val("rst_last_gnt", last_gnt, 1);
        check_val("rst_o0_msg", {o0_src, o0_dst, o0_dat, o0_red}, 0);
        reset = 1'b1;

        // 1: async reset while parked in S_OREQ
        sink_mode = 1;
        m_a = mk(4, 9, 16'h00A5, 1'b0);
        exp_q.push_back(m_a);
        send(0, m_a);
        n = 0;
        while (!o0_req && n < 50) begin
            @(negedge src_clk);
            n++;
        end
        check_val("t1_oreq_up", o0_req, 1);
        #2 reset = 1'b0;
        #1;
        check_val("t1_rst_o0_req", o0_req, 0);
        check_val("t1_rst_acks", {i0_ack, i1_ack}, 0);
        check_val("t1_rst_fwd", fwd_cnt, 0);
        check_val("t1_rst_last_gnt", last_gnt, 1);
        repeat (3) @(negedge src_clk);
        reset = 1'b1;
        sink_mode = 0;
        r0 = oreq_rises;
        repeat (6) @(negedge src_clk);
        check_val("t1_idle_after_rst", oreq_rises, r0);
        check_val("t1_o0_dat_cleared", o0_dat, 0);

        // 2: single message on i0
        i1_seen = 1'b0;
        m_b = mk(1, 2, 5, 1'b0);
        exp_q.push_back(m_b);
        send(0, m_b);
        wait_fwd(1);
        check_val("t2_o0_dat", o0_dat, 5);
        check_val("t2_o0_dst", o0_dst, 2);
        check_val("t2_ack_before_oreq", (ack_cyc[0] < oreq_cyc), 1);
        check_val("t2_oreq_width", last_w, 2);
        check_val("t2_i1_ack_quiet", i1_seen, 0);
        check_val("t2_last_gnt", last_gnt, 0);

        // 3: both inputs contend for four messages each
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk(0, 3, k, 1'b0));
            exp_q.push_back(mk(1, 3, 8 + k, 1'b0));
        end
        fork
            begin
                for (int k = 0; k < 4; k++) send(0, mk(0, 3, k, 1'b0));
            end
            begin
                for (int k = 0; k < 4; k++) send(1, mk(1, 3, 8 + k, 1'b0));
            end
        join
        wait_fwd(8);
        check_val("t3_sb_drained", exp_q.size(), 0);
        check_val("t3_last_gnt", last_gnt, 1);

        // 4: o0_ack already high when i1 is granted
        apply_reset();
        sink_mode = 2;
        m_c = mk(1, 6, 16'h0033, 1'b0);
        exp_q.push_back(m_c);
        send(1, m_c);
        wait_fwd(1);
        w_c = last_w;
        check_val("t4_oreq_width", w_c, 1);
        check_val("t4_oreq_low_in_odone", o0_req, 0);
        check_val("t4_last_gnt_i1", last_gnt, 1);
        m_d = mk(0, 7, 16'h0044, 1'b0);
        exp_q.push_back(m_d);
        fork
            send(0, m_d);
            begin
                bit early;
                early = 1'b0;
                repeat (5) begin
                    @(negedge src_clk);
                    if (i0_ack) early = 1'b1;
                end
                check_val("t4_held_in_odone", early, 0);
                sink_mode = 0;
            end
        join
        wait_fwd(2);
        check_val("t4_last_gnt_i0", last_gnt, 0);

        // 5/6: corrupted redundancy followed by a good message on i1
        apply_reset();
        m_e = mk(1, 5, 16'h0055, 1'b1);
        m_f = mk(1, 5, 7, 1'b0);
`ifdef NS_ARB_REDUN_CHECK_EN
        exp_q.push_back(m_f);
`else
        exp_q.push_back(m_e);
        exp_q.push_back(m_f);
`endif
        send(1, m_e);
        send(1, m_f);
`ifdef NS_ARB_REDUN_CHECK_EN
        wait_fwd(1);
        check_val("t5_err_cnt", err_cnt, 1);
`else
        wait_fwd(2);
        check_val("t6_err_cnt", err_cnt, 0);
`endif
        check_val("t56_o0_dat", o0_dat, 7);
        check_val("t56_last_gnt", last_gnt, 1);
        check_val("t56_sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
